// File: rtl/uart_rx.sv
// uart_rx: receives 8-data, even-parity, 1-stop UART frames from the rx1 line.
// The line is oversampled with clk. Bits are sampled mid-period, timed from the start edge.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx1,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          r_state;
  logic            r_sync;
  logic            r_rx_s;
  logic            r_rx_d;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic [7:0]      r_data_out;
  logic            r_data_valid;
  logic            r_parity_error;
  logic            r_frame_error;
  logic            r_busy;

  logic            w_fall;
  logic            w_sample;

  assign w_fall   = r_rx_d & ~r_rx_s;
  assign w_sample = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchronizer resets to the idle level so no false start edge appears.
      r_sync         <= 1'b1;
      r_rx_s         <= 1'b1;
      r_rx_d         <= 1'b1;
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_bit_idx      <= 3'd0;
      r_shift        <= 8'h00;
      r_parity       <= 1'b0;
      r_data_out     <= 8'h00;
      r_data_valid   <= 1'b0;
      r_parity_error <= 1'b0;
      r_frame_error  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_sync         <= rx1;
      r_rx_s         <= r_sync;
      r_rx_d         <= r_rx_s;
      r_data_valid   <= 1'b0;
      r_parity_error <= 1'b0;
      r_frame_error  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (w_sample) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= r_rx_s;
            r_bit_idx          <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_PARITY;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_PARITY: begin
          if (w_sample) begin
            r_cnt    <= '0;
            r_parity <= r_rx_s;
            r_state  <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (w_sample) begin
            // The byte is presented even on a framing error; only the strobes differ.
            r_cnt          <= '0;
            r_data_out     <= r_shift;
            r_data_valid   <= r_rx_s;
            r_parity_error <= r_rx_s & (r_parity ^ (^r_shift));
            r_frame_error  <= ~r_rx_s;
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out     = r_data_out;
  assign data_valid   = r_data_valid;
  assign parity_error = r_parity_error;
  assign frame_error  = r_frame_error;
  assign busy         = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level timing model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_uart_rx;

  localparam int C        = 16;
  localparam int H        = C / 2;
  localparam int STOP_OFS = 2 + H + 10 * C + 1;  // pin start edge to strobe cycle

  logic       clk = 1'b0;
  logic       reset;
  logic       rx1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx1          (rx1),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Frame-level model: strobe events, busy windows, and reset points.
  typedef struct {int cyc; logic [7:0] d; logic dv; logic pe; logic fe;} ev_t;
  typedef struct {int lo; int hi;} iv_t;
  ev_t        ev_q[$];
  iv_t        iv_q[$];
  int         rst_q[$];
  logic [7:0] m_data = 8'h00;
  logic       m_dv, m_pe, m_fe, m_busy;
  logic       cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      m_dv = 1'b0;
      m_pe = 1'b0;
      m_fe = 1'b0;
      if (rst_q.size() > 0 && rst_q[0] == cyc) begin
        m_data = 8'h00;
        void'(rst_q.pop_front());
      end
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        m_dv   = ev_q[0].dv;
        m_pe   = ev_q[0].pe;
        m_fe   = ev_q[0].fe;
        m_data = ev_q[0].d;
        void'(ev_q.pop_front());
      end
      m_busy = 1'b0;
      foreach (iv_q[k]) if (cyc >= iv_q[k].lo && cyc < iv_q[k].hi) m_busy = 1'b1;
      chk($sformatf("cycle%0d {dv,pe,fe,busy,data}", cyc),
          {20'd0, data_valid, parity_error, frame_error, busy, data_out},
          {20'd0, m_dv, m_pe, m_fe, m_busy, m_data});
    end
  end

  // Observed strobes, for the literal per-scenario expectations.
  typedef struct {int cyc; logic [7:0] d; logic pe;} pl_t;
  pl_t dv_q[$];
  int  fe_cnt   = 0;
  int  busy_cnt = 0;

  always @(negedge clk) begin
    if (data_valid) dv_q.push_back(pl_t'{cyc, data_out, parity_error});
    if (frame_error) fe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    dv_q.delete();
    fe_cnt   = 0;
    busy_cnt = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, output int n0);
    logic [10:0] bits;
    n0 = cyc;
    ev_q.push_back(ev_t'{n0 + STOP_OFS, d, stop, stop && (par != ^d), !stop});
    iv_q.push_back(iv_t'{n0 + 3, n0 + STOP_OFS});
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx1 = bits[i];
      wait_cycles(C);
    end
  endtask

  int n, r;

  initial begin
    reset = 1'b1;
    rx1   = 1'b1;
    wait_cycles(3);
    reset  = 1'b0;
    cmp_en = 1'b1;
    chk("reset data_out", data_out, 8'h00);
    chk("reset data_valid", data_valid, 1'b0);
    chk("reset parity_error", parity_error, 1'b0);
    chk("reset frame_error", frame_error, 1'b0);
    chk("reset busy", busy, 1'b0);
    wait_cycles(2 * C);

    // Good byte
    clear_obs();
    send_frame(8'hA5, 1'b0, 1'b1, n);
    chk("A5 pulses", dv_q.size(), 1);
    if (dv_q.size() >= 1) begin
      chk("A5 pulse cycle", dv_q[0].cyc, n + 2 + 169);
      chk("A5 data", dv_q[0].d, 8'hA5);
      chk("A5 parity_error", dv_q[0].pe, 1'b0);
    end
    chk("A5 frame_error", fe_cnt, 0);
    wait_cycles(C);

    // Parity error
    clear_obs();
    send_frame(8'h01, 1'b0, 1'b1, n);
    chk("01 pulses", dv_q.size(), 1);
    if (dv_q.size() >= 1) begin
      chk("01 data", dv_q[0].d, 8'h01);
      chk("01 parity_error", dv_q[0].pe, 1'b1);
    end
    wait_cycles(C);

    // Framing error then break
    clear_obs();
    send_frame(8'h3C, 1'b0, 1'b0, n);
    wait_cycles(20 * C);
    chk("break busy", busy, 1'b0);
    wait_cycles(20 * C);
    chk("3C frame_error pulses", fe_cnt, 1);
    chk("3C data_valid pulses", dv_q.size(), 0);
    chk("3C data_out", data_out, 8'h3C);
    rx1 = 1'b1;
    wait_cycles(2 * C);
    clear_obs();
    send_frame(8'h11, 1'b0, 1'b1, n);
    chk("11 pulses", dv_q.size(), 1);
    if (dv_q.size() >= 1) chk("11 data", dv_q[0].d, 8'h11);
    wait_cycles(C);

    // Start glitch: busy from T0+1 until the half-bit sample returns to idle
    clear_obs();
    n = cyc;
    iv_q.push_back(iv_t'{n + 3, n + 3 + H});
    rx1 = 1'b0;
    wait_cycles(4);
    rx1 = 1'b1;
    wait_cycles(2 * C);
    chk("glitch busy cycles", busy_cnt, 8);
    chk("glitch data_valid", dv_q.size(), 0);
    chk("glitch frame_error", fe_cnt, 0);

    // Back-to-back frames
    clear_obs();
    send_frame(8'h00, 1'b0, 1'b1, n);
    send_frame(8'hFF, 1'b0, 1'b1, n);
    chk("b2b pulses", dv_q.size(), 2);
    if (dv_q.size() >= 2) begin
      chk("b2b spacing", dv_q[1].cyc - dv_q[0].cyc, 176);
      chk("b2b data0", dv_q[0].d, 8'h00);
      chk("b2b data1", dv_q[1].d, 8'hFF);
      chk("b2b parity", {dv_q[0].pe, dv_q[1].pe}, 2'b00);
    end
    chk("b2b frame_error", fe_cnt, 0);
    wait_cycles(C);

    // Reset after data bit 3 of 0x5A
    clear_obs();
    n = cyc;
    r = n + 5 * C;
    iv_q.push_back(iv_t'{n + 3, r + 1});
    rst_q.push_back(r + 1);
    rx1 = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 4; i++) begin
      rx1 = (8'h5A >> i) & 8'h01;
      wait_cycles(C);
    end
    reset = 1'b1;
    rx1   = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(2 * C);
    chk("abandoned pulses", dv_q.size(), 0);
    chk("abandoned frame_error", fe_cnt, 0);
    chk("post-reset data_out", data_out, 8'h00);
    send_frame(8'hC3, 1'b0, 1'b1, n);
    chk("C3 pulses", dv_q.size(), 1);
    if (dv_q.size() >= 1) chk("C3 data", dv_q[0].d, 8'hC3);
    chk("C3 data_out", data_out, 8'hC3);
    wait_cycles(2 * C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
